// File: rtl/sram_test_sequencer.sv
// sram_test_sequencer: scan or load an instruction word, then replay it as a single SRAM transaction.
module sram_test_sequencer #(
  parameter int NUM_SRAM = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int WMASK_W = 4,
  parameter int READ_LAT = 1,
  localparam int P_W = ADDR_W + DATA_W + 2 + WMASK_W,
  localparam int REG_W = 4 + 2 * P_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       gpio_in_scan,
  input  logic                       gpio_bit,
  input  logic                       la_in_load,
  input  logic [REG_W-1:0]           la_bits,
  input  logic                       gpio_out_scan,
  input  logic                       go,
  output logic [NUM_SRAM-1:0]        sram_sel,
  output logic                       csb0,
  output logic                       web0,
  output logic                       csb1,
  output logic                       web1,
  output logic [WMASK_W-1:0]         wmask0,
  output logic [WMASK_W-1:0]         wmask1,
  output logic [ADDR_W-1:0]          addr0,
  output logic [ADDR_W-1:0]          addr1,
  output logic [DATA_W-1:0]          din0,
  output logic [DATA_W-1:0]          din1,
  input  logic [NUM_SRAM*DATA_W-1:0] dout0_in,
  input  logic [NUM_SRAM*DATA_W-1:0] dout1_in,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [DATA_W-1:0]          la_data0,
  output logic [DATA_W-1:0]          la_data1,
  output logic                       gpio_out
);
  localparam int WE = WMASK_W;
  localparam int CB = WMASK_W + 1;
  localparam int DI = WMASK_W + 2;
  localparam int AD = WMASK_W + 2 + DATA_W;
  localparam int P0 = P_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
  state_t state, state_n;
  logic [REG_W-1:0] rg;
  logic [2:0] cnt;
  logic err_pulse, idle, iss, go_ok, cs_ok, cap0, cap1;
  logic [3:0] cs;
  logic [DATA_W-1:0] d0, d1;
  always_comb begin
    cs = rg[REG_W-1 -: 4];
    cs_ok = int'(cs) < NUM_SRAM;
    idle = state == IDLE;
    iss = state == ISSUE;
    go_ok = idle && !gpio_in_scan && !la_in_load && go;
    cap0 = !rg[P0+CB] && rg[P0+WE];
    cap1 = !rg[CB] && rg[WE];
    d0 = dout0_in[DATA_W*int'(cs) +: DATA_W];
    d1 = dout1_in[DATA_W*int'(cs) +: DATA_W];
    state_n = idle ? ((go_ok && cs_ok) ? ISSUE : IDLE)
            : iss ? WAIT
            : (state == WAIT) ? ((cnt == 3'd0) ? CAPTURE : WAIT)
            : IDLE;
  end
  // SRAM pins are only active during ISSUE, so an async reset drops them at once
  always_comb begin
    sram_sel = iss ? NUM_SRAM'(1) << cs : '0;
    csb0 = iss ? rg[P0+CB] : 1'b1;
    web0 = iss ? rg[P0+WE] : 1'b1;
    wmask0 = iss ? rg[P0 +: WMASK_W] : '0;
    din0 = iss ? rg[P0+DI +: DATA_W] : '0;
    addr0 = iss ? rg[P0+AD +: ADDR_W] : '0;
    csb1 = iss ? rg[CB] : 1'b1;
    web1 = iss ? rg[WE] : 1'b1;
    wmask1 = iss ? rg[0 +: WMASK_W] : '0;
    din1 = iss ? rg[DI +: DATA_W] : '0;
    addr1 = iss ? rg[AD +: ADDR_W] : '0;
    busy = !idle;
    done = (state == CAPTURE) || err_pulse;
    gpio_out = rg[0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rg <= '0;
      cnt <= '0;
      err <= 1'b0;
      err_pulse <= 1'b0;
      la_data0 <= '0;
      la_data1 <= '0;
    end else begin
      err_pulse <= go_ok && !cs_ok;
      if (go_ok && !cs_ok) err <= 1'b1;
      else if (idle && !gpio_in_scan && la_in_load) err <= 1'b0;
      if (iss) cnt <= 3'(READ_LAT - 1);
      else if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (idle) begin
        if (gpio_in_scan) rg <= {rg[REG_W-2:0], gpio_bit};
        else if (la_in_load) rg <= la_bits;
        else if (!go && gpio_out_scan) rg <= {1'b0, rg[REG_W-1:1]};
      end
      if (state == CAPTURE) begin
        if (cap0) begin
          rg[P0+DI +: DATA_W] <= d0;
          la_data0 <= d0;
        end
        if (cap1) begin
          rg[DI +: DATA_W] <= d1;
          la_data1 <= d1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sram_test_sequencer.sv
// tb_sram_test_sequencer: directed vectors with hand-computed expectations for the SRAM test sequencer.
module tb_sram_test_sequencer;
  localparam int NS = 8;
  localparam int RW = 112;
  logic clk = 0;
  logic reset = 1;
  logic gpio_in_scan = 0, gpio_bit = 0, la_in_load = 0, gpio_out_scan = 0, go = 0;
  logic [RW-1:0] la_bits = '0;
  logic [NS-1:0] sram_sel;
  logic csb0, web0, csb1, web1, busy, done, err, gpio_out;
  logic [3:0] wmask0, wmask1;
  logic [15:0] addr0, addr1;
  logic [31:0] din0, din1, la_data0, la_data1;
  logic [NS*32-1:0] dout0_in, dout1_in;
  logic [RW-1:0] v, got;
  int total = 0;
  int bad = 0;

  sram_test_sequencer dut (
    .clk(clk), .reset(reset), .gpio_in_scan(gpio_in_scan), .gpio_bit(gpio_bit),
    .la_in_load(la_in_load), .la_bits(la_bits), .gpio_out_scan(gpio_out_scan), .go(go),
    .sram_sel(sram_sel), .csb0(csb0), .web0(web0), .csb1(csb1), .web1(web1),
    .wmask0(wmask0), .wmask1(wmask1), .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
    .dout0_in(dout0_in), .dout1_in(dout1_in), .busy(busy), .done(done), .err(err),
    .la_data0(la_data0), .la_data1(la_data1), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] word(input logic [3:0] cs,
      input logic [15:0] a0, input logic [31:0] di0, input logic c0, input logic w0, input logic [3:0] m0,
      input logic [15:0] a1, input logic [31:0] di1, input logic c1, input logic w1, input logic [3:0] m1);
    return {cs, a0, di0, c0, w0, m0, a1, di1, c1, w1, m1};
  endfunction

  task automatic load(input logic [RW-1:0] w);
    la_bits = w;
    la_in_load = 1;
    step();
    la_in_load = 0;
  endtask

  initial begin
    for (int k = 0; k < NS; k++) begin
      dout0_in[k*32 +: 32] = (k == 2) ? 32'hDEADBEEF : 32'h1000_0000 + k;
      dout1_in[k*32 +: 32] = 32'hA000_0000 + k;
    end
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_csb", {csb0, csb1, web0, web1}, 4'hF);
    chk("rst_sel", sram_sel, 0);
    chk("rst_la", {la_data0, la_data1}, 0);
    reset = 0;
    // read through port 0 from macro 2
    load(word(2, 16'h0010, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    go = 1;
    step();
    go = 0;
    chk("rd_sel", sram_sel, 8'b0000_0100);
    chk("rd_ctl", {csb0, web0, csb1}, 3'b011);
    chk("rd_addr", addr0, 16'h0010);
    chk("rd_busy", busy, 1);
    step();
    chk("rd_wait_sel", {sram_sel, csb0, done}, {8'h0, 1'b1, 1'b0});
    step();
    chk("rd_done", {done, busy}, 2'b11);
    step();
    chk("rd_idle", {done, busy}, 2'b00);
    chk("rd_la0", la_data0, 32'hDEADBEEF);
    chk("rd_la1", la_data1, 0);
    // held go: din field replays the captured word, then re-arms after one idle cycle
    go = 1;
    step();
    chk("rd_din_field", din0, 32'hDEADBEEF);
    step();
    step();
    chk("b2b_done", done, 1);
    step();
    chk("b2b_idle", {busy, sram_sel}, 9'h0);
    step();
    chk("b2b_sel", sram_sel, 8'b0000_0100);
    go = 0;
    step();
    step();
    step();
    // write on port 0 to macro 0
    load(word(0, 16'h0020, 32'h12345678, 0, 0, 4'hF, 0, 0, 1, 1, 0));
    go = 1;
    step();
    go = 0;
    chk("wr_issue", {sram_sel, csb0, web0, wmask0, addr0}, {8'h01, 1'b0, 1'b0, 4'hF, 16'h0020});
    chk("wr_din", din0, 32'h12345678);
    step();
    chk("wr_wait", {web0, wmask0, din0}, {1'b1, 4'h0, 32'h0});
    step();
    step();
    chk("wr_la0", la_data0, 32'hDEADBEEF);
    // read on port 1 from macro 5
    load(word(5, 0, 0, 1, 1, 0, 16'h0033, 0, 0, 1, 0));
    go = 1;
    step();
    go = 0;
    chk("p1_issue", {sram_sel, csb0, csb1, web1, addr1}, {8'h20, 1'b1, 1'b0, 1'b1, 16'h0033});
    step();
    step();
    step();
    chk("p1_la", {la_data0, la_data1}, {32'hDEADBEEF, 32'hA000_0005});
    // out-of-range chip select
    load(word(9, 16'h0001, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    go = 1;
    step();
    go = 0;
    chk("bad_pulse", {done, err, busy, csb0, csb1, sram_sel}, {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0});
    step();
    chk("bad_hold", {done, err, busy}, 3'b010);
    step();
    chk("bad_sticky", err, 1);
    load('0);
    chk("bad_clear", err, 0);
    // serial scan in, then out LSB-first
    v = 112'h3A5C_0F1E_2D3C_4B5A_6978_8796_A5B4;
    gpio_in_scan = 1;
    for (int i = RW - 1; i >= 0; i--) begin
      gpio_bit = v[i];
      step();
    end
    gpio_in_scan = 0;
    gpio_bit = 0;
    gpio_out_scan = 1;
    for (int i = 0; i < RW; i++) begin
      got[i] = gpio_out;
      step();
    end
    gpio_out_scan = 0;
    chk("scan_bits", got, v);
    chk("scan_empty", gpio_out, 0);
    go = 1;
    step();
    go = 0;
    chk("scan_zero", {sram_sel, csb0, web0, addr0, din0, csb1}, {8'h01, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0});
    step();
    step();
    step();
    // async reset during WAIT
    load(word(2, 16'h0010, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    go = 1;
    step();
    go = 0;
    step();
    chk("pre_rst", {busy, la_data0}, {1'b1, 32'hDEADBEEF});
    reset = 1;
    #2;
    chk("mid_rst", {busy, done, csb0, csb1, la_data0, la_data1}, {1'b0, 1'b0, 1'b1, 1'b1, 64'h0});
    step();
    reset = 0;
    load(word(2, 16'h0010, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    go = 1;
    step();
    go = 0;
    step();
    step();
    chk("post_rst_done", done, 1);
    step();
    chk("post_rst_la", la_data0, 32'hDEADBEEF);
    // scan beats go; go during WAIT is ignored
    gpio_in_scan = 1;
    gpio_bit = 0;
    go = 1;
    step();
    gpio_in_scan = 0;
    chk("scan_wins", {busy, sram_sel}, 9'h0);
    step();
    chk("shift_cs", sram_sel, 8'b0001_0000);
    step();
    chk("wait_busy", busy, 1);
    step();
    go = 0;
    chk("ign_done", done, 1);
    step();
    chk("ign_idle", {busy, done}, 2'b00);
    step();
    chk("ign_stay", {busy, sram_sel}, 9'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_test_sequencer.md
SRAM_TEST_SEQUENCER -- requirements
Module: sram_test_sequencer

Interface
REQ-001 Parameter NUM_SRAM, default 8, number of attached SRAM macros (1..16).
REQ-002 Parameter ADDR_W, default 16, address field width per port.
REQ-003 Parameter DATA_W, default 32, data field width per port.
REQ-004 Parameter WMASK_W, default 4, write-mask field width per port.
REQ-005 Parameter READ_LAT, default 1, SRAM read latency in clk cycles (1..7).
REQ-006 Derived constant: P_W = ADDR_W+DATA_W+2+WMASK_W; REG_W = 4+2*P_W (112 at defaults).
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 gpio_in_scan  input  1  shift gpio_bit into instruction register.
REQ-010 gpio_bit  input  1  serial input data.
REQ-011 la_in_load  input  1  parallel load from la_bits.
REQ-012 la_bits  input  REG_W  parallel instruction word.
REQ-013 gpio_out_scan  input  1  shift instruction register toward LSB.
REQ-014 go  input  1  start one SRAM transaction.
REQ-015 sram_sel  output  NUM_SRAM  one-hot macro select.
REQ-016 csb0, web0, csb1, web1  output  1 each  active-low port controls.
REQ-017 wmask0, wmask1  output  WMASK_W; addr0, addr1  output  ADDR_W; din0, din1  output  DATA_W.
REQ-018 dout0_in, dout1_in  input  NUM_SRAM*DATA_W  concatenated macro outputs, macro k at bits [k*DATA_W +: DATA_W].
REQ-019 busy  output  1;  done  output  1;  err  output  1 (sticky).
REQ-020 la_data0, la_data1  output  DATA_W  last captured read data; gpio_out  output  1  register bit 0.

Function
REQ-021 Register fields, MSB down: chip_select[4], then port0 {addr, din, csb, web, wmask}, then port1 {addr, din, csb, web, wmask}.
REQ-022 FSM states IDLE, ISSUE, WAIT, CAPTURE; busy=1 in all states except IDLE.
REQ-023 In IDLE, priority per cycle: gpio_in_scan > la_in_load > go > gpio_out_scan.
REQ-024 gpio_in_scan: register <= {register[REG_W-2:0], gpio_bit}.
REQ-025 la_in_load: register <= la_bits.
REQ-026 gpio_out_scan: register <= {1'b0, register[REG_W-1:1]}; gpio_out is always register[0].
REQ-027 Scan, load and go are ignored while busy=1.
REQ-028 go with chip_select >= NUM_SRAM: no access, err set to 1, done pulses 1 cycle, and the FSM stays in IDLE.
REQ-029 go with valid chip_select: next state ISSUE.
REQ-030 ISSUE lasts exactly 1 cycle: sram_sel = one-hot(chip_select); csb/web/wmask/addr/din driven from the fields.
REQ-031 Outside ISSUE: csb0=csb1=1, web0=web1=1, sram_sel=0, other SRAM outputs 0.
REQ-032 WAIT lasts exactly READ_LAT cycles, counted by a 3-bit down-counter.
REQ-033 CAPTURE lasts 1 cycle: done=1, the FSM returns to IDLE, and dout of the selected macro is sampled.
REQ-034 Port p capture: only when field csb_p=0 and web_p=1; dout_p overwrites the din_p field and la_data_p; otherwise both are unchanged.
REQ-035 Transaction latency: go edge to done = 1+READ_LAT+1 cycles; busy is high for 2+READ_LAT cycles.
REQ-036 go held high re-arms only from IDLE: back-to-back transactions have 1 IDLE cycle between done and the next ISSUE.
REQ-037 err is cleared only by reset or by la_in_load.

Reset
REQ-038 On reset assertion, immediately: register=0, state=IDLE, counter=0, busy=0, done=0, err=0, la_data0=la_data1=0, and SRAM outputs to their inactive values per REQ-031.
REQ-039 Reset mid-transaction aborts the access; csb0 and csb1 go high asynchronously, and no capture occurs.
REQ-040 First active edge after reset deassertion is treated as IDLE.

Verification
REQ-041 Load la_bits with cs=2, addr0=0x0010, csb0=0, web0=1, csb1=1; go; macro 2 dout0=0xDEADBEEF.
 -> sram_sel=8'b00000100 for 1 cycle; done at go+1+READ_LAT+1; la_data0=0xDEADBEEF; din0 field=0xDEADBEEF.
REQ-042 Write: cs=0, csb0=0, web0=0, wmask0=0xF, din0=0x12345678; go.
 -> web0=0 and din0=0x12345678 during ISSUE only; la_data0 unchanged.
REQ-043 cs=9 with NUM_SRAM=8; go.
 -> no csb low; done 1 cycle; err=1 until the next la_in_load.
REQ-044 Scan 112 bits via gpio_in_scan, then 112 gpio_out_scan cycles.
 -> gpio_out reproduces bits LSB-first; register ends at 0.
REQ-045 Assert reset during WAIT.
 -> busy=0, csb high, and la_data=0 immediately; a subsequent go works normally.
REQ-046 gpio_in_scan and go asserted together in IDLE, then go asserted during WAIT.
 -> scan wins and no transaction starts; the go during WAIT is ignored.
